// File: rtl/dropout_pkg.sv
// Shared types and constants for the random-dropout frame controller.
package dropout_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [7:0]  RATE_DROP_ALL = 8'hFF;

endpackage

// File: rtl/dropout_lfsr.sv
// Galois right-shift LFSR with seed load (zero seed falls back to SEED) and step enable.
module dropout_lfsr
  import dropout_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_next;

  always_comb begin
    w_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_W'(LFSR_TAPS) : '0);
  end

  // An all-zero state would lock the LFSR, so a zero seed is replaced by SEED.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= (i_seed == '0) ? SEED : i_seed;
    end else if (i_step) begin
      r_lfsr <= w_next;
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/dropout_frame_ctrl.sv
// Frame sequencer for lane-wise random dropout: masks each accepted beat with LFSR keep bits.
// Optional DROPOUT_STATS_EN builds a saturating dropped-bit counter on drop_count.
module dropout_frame_ctrl
  import dropout_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_rate,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [15:0]       drop_count
);

  localparam int             CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_rate;
  logic [LFSR_W-1:0]   r_seed;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [LFSR_W-1:0]   w_lfsr;
  logic [DATA_W-1:0]   w_mask;
  logic                w_in_ready, w_accept, w_load;

  // Lane i compares the low byte of the LFSR rotated right by 2i against the rate.
  function automatic logic [DATA_W-1:0] keep_mask(input logic [LFSR_W-1:0] lfsr,
                                                  input logic [7:0]        rate);
    logic [LFSR_W-1:0] rot;
    keep_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rot          = (lfsr >> (2 * i)) | (lfsr << (LFSR_W - 2 * i));
      keep_mask[i] = (rate != RATE_DROP_ALL) && (rot[7:0] >= rate);
    end
  endfunction

  assign w_mask     = keep_mask(w_lfsr, r_rate);
  assign w_in_ready = (r_state == RUN) && enable && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  dropout_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_seed  (r_seed),
    .i_step  (w_accept),
    .o_state (w_lfsr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE:  if (start && enable) w_state_nxt = LOAD;
      LOAD:  if (enable) begin
               w_state_nxt = RUN;
               w_load      = 1'b1;
             end
      RUN:   if (w_accept && (r_beat_cnt == LAST_BEAT)) w_state_nxt = FLUSH;
      FLUSH: if (enable && (!r_out_valid || out_ready)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rate     <= 8'h00;
      r_seed     <= SEED;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && cfg_we) begin
        r_rate <= cfg_rate;
        r_seed <= cfg_seed;
      end
      if (w_load) begin
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  // A new accept refills the output register in the same cycle it drains: no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data & w_mask;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef DROPOUT_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0]       acc,
                                          input logic [DATA_W-1:0] mask);
    logic [16:0] sum;
    sum = {1'b0, acc} + 17'($countones(~mask));
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [15:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (reset || (r_state == LOAD)) begin
      r_drop_count <= 16'h0;
    end else if (w_accept) begin
      r_drop_count <= sat_add(r_drop_count, w_mask);
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = 16'h0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != IDLE);

endmodule
